// File: rtl/pe_matmul_seq.sv
// Job controller for one processing element: walks every (i,j) of C = A x B,
// streams the K operand pairs of each dot product into the PE and writes the result back.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for go
//   S_ISSUE | reading A/B for the current (i,j,k), GAP idle cycles between reads
//   S_WAIT  | last pair sent, waiting for pe_output_valid or the timeout
//   S_WRITE | one-cycle C write, then advance (i,j)
//   S_DONE  | one-cycle done pulse, back to idle
module pe_matmul_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 4,
    parameter int K          = 16,
    parameter int P          = 4,
    parameter int GAP        = 1,
    parameter int TIMEOUT    = 256,
    localparam int AAW       = (M * K > 1) ? $clog2(M * K) : 1,
    localparam int BAW       = (K * P > 1) ? $clog2(K * P) : 1,
    localparam int CAW       = (M * P > 1) ? $clog2(M * P) : 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  a_rd_en,
    output logic [AAW-1:0]        a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  b_rd_en,
    output logic [BAW-1:0]        b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  pe_start,
    output logic                  pe_valid_in,
    output logic                  pe_last,
    output logic [DATA_WIDTH-1:0] pe_a,
    output logic [DATA_WIDTH-1:0] pe_b,
    input  logic [DATA_WIDTH-1:0] pe_c,
    input  logic                  pe_output_valid,
    output logic                  c_wr_en,
    output logic [CAW-1:0]        c_wr_addr,
    output logic [DATA_WIDTH-1:0] c_wr_data
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [JW-1:0]         j_q, j_d;
    logic [KW-1:0]         k_q, k_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic                  vld_q, vld_d;
    logic                  start_q, start_d;
    logic                  last_q, last_d;
    logic                  rd_en;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            gap_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            c_q     <= '0;
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            c_q     <= c_d;
            vld_q   <= vld_d;
            start_q <= start_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        gap_d   = gap_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        c_d     = c_q;
        rd_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    err_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    gap_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    rd_en = 1'b1;
                    if (k_q == KW'(K - 1)) begin
                        tmr_d   = TW'(TIMEOUT - 1);
                        state_d = S_WAIT;
                    end else begin
                        k_d   = k_q + 1'b1;
                        gap_d = GW'(GAP);
                    end
                end
            end
            S_WAIT: begin
                if (pe_output_valid) begin
                    c_d     = pe_c;
                    state_d = S_WRITE;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WRITE: begin
                k_d     = '0;
                gap_d   = '0;
                state_d = S_ISSUE;
                if (j_q == JW'(P - 1)) begin
                    j_d = '0;
                    if (i_q == IW'(M - 1)) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PE framing is the read strobe delayed by the one-cycle memory latency
    always_comb begin
        vld_d   = rd_en;
        start_d = rd_en && (k_q == '0);
        last_d  = rd_en && (k_q == KW'(K - 1));
    end

    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign a_rd_en     = rd_en;
    assign b_rd_en     = rd_en;
    assign a_rd_addr   = AAW'(i_q) * AAW'(K) + AAW'(k_q);
    assign b_rd_addr   = BAW'(k_q) * BAW'(P) + BAW'(j_q);
    assign pe_start    = start_q;
    assign pe_valid_in = vld_q;
    assign pe_last     = last_q;
    assign pe_a        = a_rd_data;
    assign pe_b        = b_rd_data;
    assign c_wr_en     = (state_q == S_WRITE);
    assign c_wr_addr   = CAW'(i_q) * CAW'(P) + CAW'(j_q);
    assign c_wr_data   = c_q;

endmodule
